noc_input_unit: RTL
===================

// Module: noc_input_unit
// PURPOSE
//  Parametrised wormhole input unit for the 3D-mesh router: one per router input port (E/W/N/S/PE/UP/DOWN).
//  Buffers incoming flits in a circular FIFO and computes an XYZ dimension-order route from the head flit.
//  Holds a per-packet lock (IDLE/ROUTE/ACTIVE) and issues one-hot output requests to the switch allocator.
//  Returns one credit upstream per flit dequeued; flags protocol and overflow violations.
// PARAMETERS
//  FW     40  flit width; type field = flit[FW-1:FW-2]
//  DEPTH  4   FIFO entries, power of 2, >=2
//  XW     2   width of each destination coordinate field (X, Y, Z)
//  MY_X   0   this router's X coordinate
//  MY_Y   0   this router's Y coordinate
//  MY_Z   0   this router's Z coordinate
//  NPORT  7   output ports; fixed order 0:E 1:W 2:N 3:S 4:PE 5:UP 6:DOWN
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  in_valid     in   1      flit present on in_flit this cycle
//  in_flit      in   FW     incoming flit
//  credit_out   out  1      1-cycle pulse, one per flit dequeued, returned upstream
//  out_req      out  NPORT  one-hot output-port request of the current packet
//  out_grant    in   1      allocator grants this input for the current cycle (downstream space is guaranteed)
//  out_valid    out  1      out_flit valid to crossbar
//  out_flit     out  FW     registered departing flit
//  proto_err    out  1      sticky: non-head flit found at FIFO head while IDLE
//  ovf_err      out  1      sticky: in_valid while full with no pop
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFO empty, pointers/count 0, state IDLE, route 0, every output 0.
//  Reset mid-packet discards buffered flits and the lock; no credits are returned for them.
//  Flit type: 11 HEAD, 10 BODY, 01 TAIL, 00 SINGLE (head and tail in one flit).
//  Header fields: dst_x = flit[FW-3 -: XW], dst_y = next XW bits, dst_z = next XW bits.
//  FIFO:
//   - write when in_valid and (not full or pop same cycle); count += wr - pop; pointers wrap mod DEPTH
//   - full with in_valid and no pop: flit dropped, ovf_err set
//   - empty: pop is never issued
//  FSM, evaluated on the FIFO head entry:
//   - IDLE: head is HEAD/SINGLE -> ROUTE. Head is BODY/TAIL -> pop it (credit returned, not forwarded), set proto_err, stay IDLE.
//   - ROUTE: route register <= XYZ DOR result -> ACTIVE; out_req=0 in this cycle.
//   - ACTIVE: out_req = route while FIFO non-empty, else 0 (the lock is held across bubbles).
//     out_grant && |out_req -> pop; out_flit <= head, out_valid=1 next cycle.
//     Popped flit TAIL or SINGLE -> IDLE; the next head is routed no earlier than the following cycle.
//  out_grant while out_req=0 is ignored.
//  XYZ DOR: dst_x>MY_X -> E; dst_x<MY_X -> W; else dst_y>MY_Y -> N; dst_y<MY_Y -> S;
//   else dst_z>MY_Z -> UP; dst_z<MY_Z -> DOWN; else PE. Comparisons are unsigned, XW bits.
//  Latency: HEAD written at edge t -> ROUTE t+1 -> out_req high t+2 -> grant at t+2 -> out_valid t+3.
//   Sustained throughput: 1 flit/cycle in ACTIVE.
//  credit_out: registered; pulses the cycle after each pop, including proto_err discards.
//  Credits returned never exceed DEPTH outstanding.
//  out_valid is 0 in every cycle following a cycle with no pop.
// STRUCTURE
//  noc_pkg: FLIT_HEAD/BODY/TAIL/SINGLE codes, port indices P_E..P_DOWN, NPORT, default FW,
//   FSM state encodings S_IDLE/S_ROUTE/S_ACTIVE.
//  Sub-module noc_flit_fifo (FW, DEPTH): wr/rd/full/empty/count/head. Route function, FSM and
//   credit/error logic stay in noc_input_unit.
// TESTING
//  1 Reset with in_valid=1 -> FIFO stays empty; out_req=0, credit_out=0, proto_err=0, ovf_err=0.
//  2 MY=(1,1,1); SINGLE dst=(2,1,1), grant held high -> out_req=7'b0000001 (E) at t+2, out_valid at t+3, credit_out at t+3.
//  3 HEAD dst=(1,1,0) + 2 BODY + TAIL, grant tied high -> out_req=DOWN (bit6); 4 consecutive out_valid; IDLE after TAIL.
//  4 DEPTH=4: 4 flits, grant=0 -> full; 5th in_valid -> ovf_err=1. 5th flit sent in the same cycle as a pop -> accepted, no error.
//  5 BODY flit arrives in IDLE -> discarded; proto_err=1, one credit_out pulse, out_valid stays 0.
//  6 Grant toggled 1010 mid-packet, then rst asserted during BODY -> no flit lost before reset; all outputs 0 the cycle after reset.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg
//   Shared definitions for the mesh router input stage: flit type codes,
//   output port indices, default widths and the packet-lock FSM states.
//   Also holds small helpers that classify a flit type as packet start/end.
package noc_pkg;

  localparam int FW_DEFAULT = 40;
  localparam int NPORT      = 7;

  // Output port order is fixed across the whole router.
  localparam int P_E    = 0;
  localparam int P_W    = 1;
  localparam int P_N    = 2;
  localparam int P_S    = 3;
  localparam int P_PE   = 4;
  localparam int P_UP   = 5;
  localparam int P_DOWN = 6;

  typedef enum logic [1:0] {
    FLIT_SINGLE = 2'b00,
    FLIT_TAIL   = 2'b01,
    FLIT_BODY   = 2'b10,
    FLIT_HEAD   = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ROUTE  = 2'b01,
    S_ACTIVE = 2'b10
  } state_t;

  // A flit that opens a packet carries routing information.
  function automatic logic is_pkt_start(flit_type_t t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  // A flit that closes a packet releases the output lock.
  function automatic logic is_pkt_end(flit_type_t t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo
//   Circular flit buffer for one router input port.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   wr_en      request to store wr_data (accepted if not full, or if a read
//              happens in the same cycle)
//   wr_data    flit to store
//   rd_en      request to remove the head entry (ignored when empty)
//   full       all DEPTH entries occupied
//   empty      no entries stored
//   count      number of stored entries, 0..DEPTH
//   head       oldest stored entry (undefined contents when empty)
module noc_flit_fifo #(
  parameter int FW    = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [FW-1:0]              wr_data,
  input  logic                       rd_en,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [FW-1:0]              head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [FW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr];

  // A write into a full buffer is still allowed when the head leaves in the
  // same cycle, so the slot freed by the read is reused immediately.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Storage array has no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_unit.sv
// noc_input_unit
//   Wormhole input unit of the 3D-mesh router. Buffers incoming flits,
//   routes each packet by XYZ dimension order from its head flit, holds the
//   output lock for the whole packet and returns one credit per flit removed.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_valid     flit present on in_flit
//   in_flit      incoming flit
//   credit_out   one-cycle pulse per flit removed from the buffer
//   out_req      one-hot output port request of the current packet
//   out_grant    allocator grant for this input in the current cycle
//   out_valid    out_flit valid to the crossbar
//   out_flit     registered departing flit
//   proto_err    sticky: non-head flit found at the buffer head while idle
//   ovf_err      sticky: flit arrived while full and nothing left
module noc_input_unit #(
  parameter int FW    = noc_pkg::FW_DEFAULT,
  parameter int DEPTH = 4,
  parameter int XW    = 2,
  parameter int MY_X  = 0,
  parameter int MY_Y  = 0,
  parameter int MY_Z  = 0,
  parameter int NPORT = noc_pkg::NPORT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [FW-1:0]    in_flit,
  output logic             credit_out,
  output logic [NPORT-1:0] out_req,
  input  logic             out_grant,
  output logic             out_valid,
  output logic [FW-1:0]    out_flit,
  output logic             proto_err,
  output logic             ovf_err
);

  import noc_pkg::*;

  localparam logic [XW-1:0] MX = XW'(MY_X);
  localparam logic [XW-1:0] MYY = XW'(MY_Y);
  localparam logic [XW-1:0] MZ = XW'(MY_Z);

  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic [FW-1:0]           fifo_head;
  flit_type_t              head_type;
  state_t                  state;
  state_t                  state_next;
  logic [NPORT-1:0]        route_q;
  logic                    pop_fwd;
  logic                    pop_discard;
  logic                    pop;

  // Dimension-order routing: resolve X first, then Y, then Z; a packet
  // already at its destination goes to the local processing element.
  function automatic logic [NPORT-1:0] dor_route(logic [FW-1:0] f);
    logic [XW-1:0]    dx;
    logic [XW-1:0]    dy;
    logic [XW-1:0]    dz;
    logic [NPORT-1:0] r;
    dx = f[FW-3 -: XW];
    dy = f[FW-3-XW -: XW];
    dz = f[FW-3-2*XW -: XW];
    r  = '0;
    if (dx > MX)       r[P_E]    = 1'b1;
    else if (dx < MX)  r[P_W]    = 1'b1;
    else if (dy > MYY) r[P_N]    = 1'b1;
    else if (dy < MYY) r[P_S]    = 1'b1;
    else if (dz > MZ)  r[P_UP]   = 1'b1;
    else if (dz < MZ)  r[P_DOWN] = 1'b1;
    else               r[P_PE]   = 1'b1;
    return r;
  endfunction

  noc_flit_fifo #(
    .FW    (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (in_valid),
    .wr_data (in_flit),
    .rd_en   (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count),
    .head    (fifo_head)
  );

  assign head_type = flit_type_t'(fifo_head[FW-1:FW-2]);

  // Packet lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a packet start at the head claims the lock, routing
  // takes one cycle, and the lock is released when the closing flit leaves.
  // Stray body/tail flits in IDLE are discarded without changing state.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!fifo_empty && is_pkt_start(head_type)) begin
          state_next = S_ROUTE;
        end
      end
      S_ROUTE: begin
        state_next = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (pop_fwd && is_pkt_end(head_type)) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: the request is held for the whole packet but dropped
  // during bubbles so the allocator never grants an empty buffer. A grant
  // without a request is ignored.
  always_comb begin
    out_req     = '0;
    pop_fwd     = 1'b0;
    pop_discard = 1'b0;
    if (state == S_ACTIVE && !fifo_empty) begin
      out_req = route_q;
    end
    if (out_grant && |out_req) begin
      pop_fwd = 1'b1;
    end
    if (state == S_IDLE && !fifo_empty && !is_pkt_start(head_type)) begin
      pop_discard = 1'b1;
    end
  end

  assign pop = pop_fwd || pop_discard;

  // Route register is loaded once per packet from the head flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      route_q <= '0;
    end else if (state == S_ROUTE) begin
      route_q <= dor_route(fifo_head);
    end
  end

  // Departing flit, credit return and sticky error flags. Every removal,
  // including discarded stray flits, frees a buffer slot upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_flit   <= '0;
      credit_out <= 1'b0;
      proto_err  <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      out_valid  <= pop_fwd;
      credit_out <= pop;
      if (pop_fwd) begin
        out_flit <= fifo_head;
      end
      if (pop_discard) begin
        proto_err <= 1'b1;
      end
      if (in_valid && fifo_full && !pop) begin
        ovf_err <= 1'b1;
      end
    end
  end

  // Buffer occupancy, and hence outstanding credits, never exceeds DEPTH.
  assert property (@(posedge clk) disable iff (rst)
                   fifo_count <= ($clog2(DEPTH) + 1)'(DEPTH));

endmodule
